stream_mux_rr: RTL

//  N-input, W-bit streaming multiplexer with valid/ready handshakes and a

---
 rtl/stream_mux_rr.sv | 98 +++++++++
 1 files changed

// File: rtl/stream_mux_rr.sv
// N-input valid/ready stream multiplexer with a registered output stage.
// Round-robin or fixed-priority arbitration feeds a one-hot AND-OR data select.
module stream_mux_rr #(
    parameter  int W     = 8,
    parameter  int N     = 4,
    localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic [N-1:0]     in_valid,
    input  logic [N*W-1:0]   in_data,
    output logic [N-1:0]     in_ready,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic [SEL_W-1:0] out_src,
    input  logic             out_ready
);

    logic             r_out_valid;
    logic [W-1:0]     r_out_data;
    logic [SEL_W-1:0] r_out_src;
    logic [SEL_W-1:0] r_rr_ptr;

    logic             w_accept;
    logic [N-1:0]     w_grant;
    logic             w_any_grant;
    logic [SEL_W-1:0] w_src;
    logic [W-1:0]     w_data_next;
    logic [SEL_W-1:0] w_ptr_next;

    // The register can take a new beat when it is empty or being drained.
    assign w_accept = ~r_out_valid | out_ready;

    always_comb begin : arbiter
        logic             found;
        int               scan;
        logic [SEL_W-1:0] sel;
        // NOTE: every variable gets a default before any branch, so no path
        // through the block leaves it unassigned and no latch is inferred.
        w_grant = '0;
        found   = 1'b0;
        scan    = 0;
        sel     = '0;
        for (int k = 0; k < N; k++) begin
            if (mode) begin
                scan = k;
            end else begin
                scan = int'(r_rr_ptr) + k;
                if (scan >= N) begin
                    scan = scan - N;
                end
            end
            sel = SEL_W'(scan);
            if (!found && in_valid[sel]) begin
                w_grant[sel] = 1'b1;
                found        = 1'b1;
            end
        end
    end

    // Source index and data both come from the one-hot grant by AND-OR only.
    always_comb begin : select
        w_src       = '0;
        w_data_next = '0;
        for (int i = 0; i < N; i++) begin
            w_src       = w_src | (SEL_W'(i) & {SEL_W{w_grant[i]}});
            w_data_next = w_data_next | (in_data[i*W +: W] & {W{w_grant[i]}});
        end
    end

    assign w_any_grant = |w_grant;
    assign w_ptr_next  = (w_src == SEL_W'(N - 1)) ? '0 : w_src + SEL_W'(1);
    assign in_ready    = w_grant & {N{w_accept}};

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_rr_ptr    <= '0;
        end else if (w_accept) begin
            r_out_valid <= w_any_grant;
            if (w_any_grant) begin
                r_out_data <= w_data_next;
                r_out_src  <= w_src;
                r_rr_ptr   <= w_ptr_next;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;

endmodule
